// File: rtl/i2c_slave_byte_ctrl_if.sv
// Host and pad signal bundle for the byte-level I2C target controller.
// Ports: ena/slave_addr/rx_ack_en/tx_* host side, rx_*/status outputs, scl_*/sda_* pads.
interface i2c_slave_byte_ctrl_if;
    logic       ena;
    logic [6:0] slave_addr;
    logic       rx_ack_en;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_req;
    logic       tx_done;
    logic       tx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       start_det;
    logic       stop_det;
    logic       busy;
    logic       selected;
    logic       rw;
    logic       scl_i;
    logic       sda_i;
    logic       scl_o;
    logic       sda_o;
    logic       scl_oen;
    logic       sda_oen;

    modport slave (
        input  ena, slave_addr, rx_ack_en, tx_data, tx_valid,
        input  scl_i, sda_i,
        output tx_req, tx_done, tx_ack, rx_data, rx_valid,
        output start_det, stop_det, busy, selected, rw,
        output scl_o, sda_o, scl_oen, sda_oen
    );

    modport master (
        output ena, slave_addr, rx_ack_en, tx_data, tx_valid,
        output scl_i, sda_i,
        input  tx_req, tx_done, tx_ack, rx_data, rx_valid,
        input  start_det, stop_det, busy, selected, rw,
        input  scl_o, sda_o, scl_oen, sda_oen
    );
endinterface

// File: rtl/i2c_slave_byte_ctrl.sv
// Byte-level I2C target: oversampled START/STOP detect, 7-bit address match,
// byte receive to host, host-fed byte transmit with SCL stretching.
// Ports: clk, nReset (async, active-low), bus (slave modport of i2c_slave_byte_ctrl_if).
module i2c_slave_byte_ctrl (
    input  logic                   clk,
    input  logic                   nReset,
    i2c_slave_byte_ctrl_if.slave   bus
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX_WAIT, TX, TX_ACK, IGNORE
    } state_t;

    logic [1:0] scl_sync, sda_sync;
    logic       scl_dly, sda_dly;
    logic       scl_now, sda_now;
    logic       scl_rise, scl_fall, start_c, stop_c;

    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;
    logic [7:0] sh, sh_n;
    logic       ph, ph_n;
    logic [7:0] rx_data_q, rx_data_n;
    logic       rw_q, rw_n;
    logic       sel_q, sel_n;
    logic       busy_q, busy_n;
    logic       sda_oen_q, sda_oen_n;
    logic       scl_oen_q, scl_oen_n;
    logic       rx_valid_q, rx_valid_n;
    logic       tx_done_q, tx_done_n;
    logic       tx_ack_q, tx_ack_n;
    logic       start_q, start_n;
    logic       stop_q, stop_n;

    // two-flop synchronizer plus one delay flop per line
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_dly  <= 1'b1;
            sda_dly  <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], bus.scl_i};
            sda_sync <= {sda_sync[0], bus.sda_i};
            scl_dly  <= scl_sync[1];
            sda_dly  <= sda_sync[1];
        end
    end

    assign scl_now  = scl_sync[1];
    assign sda_now  = sda_sync[1];
    assign scl_rise = scl_now & ~scl_dly;
    assign scl_fall = ~scl_now & scl_dly;
    assign start_c  = scl_now & scl_dly & sda_dly & ~sda_now;
    assign stop_c   = scl_now & scl_dly & ~sda_dly & sda_now;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state      <= IDLE;
            cnt        <= 3'd7;
            sh         <= 8'h00;
            ph         <= 1'b0;
            rx_data_q  <= 8'h00;
            rw_q       <= 1'b0;
            sel_q      <= 1'b0;
            busy_q     <= 1'b0;
            sda_oen_q  <= 1'b1;
            scl_oen_q  <= 1'b1;
            rx_valid_q <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_ack_q   <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sh         <= sh_n;
            ph         <= ph_n;
            rx_data_q  <= rx_data_n;
            rw_q       <= rw_n;
            sel_q      <= sel_n;
            busy_q     <= busy_n;
            sda_oen_q  <= sda_oen_n;
            scl_oen_q  <= scl_oen_n;
            rx_valid_q <= rx_valid_n;
            tx_done_q  <= tx_done_n;
            tx_ack_q   <= tx_ack_n;
            start_q    <= start_n;
            stop_q     <= stop_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        sh_n       = sh;
        ph_n       = ph;
        rx_data_n  = rx_data_q;
        rw_n       = rw_q;
        sel_n      = sel_q;
        busy_n     = busy_q;
        sda_oen_n  = sda_oen_q;
        rx_valid_n = 1'b0;
        tx_done_n  = 1'b0;
        tx_ack_n   = tx_ack_q;
        start_n    = 1'b0;
        stop_n     = 1'b0;

        // bus conditions take priority over any byte completion
        if (!bus.ena) begin
            state_n   = IDLE;
            sel_n     = 1'b0;
            busy_n    = 1'b0;
            sda_oen_n = 1'b1;
        end else if (start_c) begin
            state_n   = ADDR;
            cnt_n     = 3'd7;
            ph_n      = 1'b0;
            sel_n     = 1'b0;
            busy_n    = 1'b1;
            sda_oen_n = 1'b1;
            start_n   = 1'b1;
        end else if (stop_c) begin
            state_n   = IDLE;
            sel_n     = 1'b0;
            busy_n    = 1'b0;
            sda_oen_n = 1'b1;
            stop_n    = 1'b1;
        end else begin
            unique case (state)
                ADDR: begin
                    if (scl_rise) begin
                        sh_n  = {sh[6:0], sda_now};
                        cnt_n = cnt - 3'd1;
                        if (cnt == 3'd0) begin
                            if (sh[6:0] == bus.slave_addr) begin
                                rw_n    = sda_now;
                                ph_n    = 1'b0;
                                state_n = ADDR_ACK;
                            end else begin
                                state_n = IGNORE;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ph) begin
                            sda_oen_n = 1'b0;
                            sel_n     = 1'b1;
                            ph_n      = 1'b1;
                        end else begin
                            sda_oen_n = 1'b1;
                            cnt_n     = 3'd7;
                            state_n   = rw_q ? TX_WAIT : RX;
                        end
                    end
                end
                RX: begin
                    if (scl_rise) begin
                        sh_n  = {sh[6:0], sda_now};
                        cnt_n = cnt - 3'd1;
                        if (cnt == 3'd0) begin
                            rx_data_n  = {sh[6:0], sda_now};
                            rx_valid_n = 1'b1;
                            ph_n       = 1'b0;
                            state_n    = RX_ACK;
                        end
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        if (!ph) begin
                            sda_oen_n = ~bus.rx_ack_en;
                            ph_n      = 1'b1;
                        end else begin
                            sda_oen_n = 1'b1;
                            cnt_n     = 3'd7;
                            state_n   = RX;
                        end
                    end
                end
                TX_WAIT: begin
                    if (bus.tx_valid) begin
                        sh_n      = bus.tx_data;
                        sda_oen_n = bus.tx_data[7];
                        cnt_n     = 3'd7;
                        state_n   = TX;
                    end
                end
                TX: begin
                    // seven shifts after the MSB, the 8th falling edge frees SDA
                    if (scl_fall) begin
                        if (cnt == 3'd0) begin
                            sda_oen_n = 1'b1;
                            ph_n      = 1'b0;
                            state_n   = TX_ACK;
                        end else begin
                            sh_n      = {sh[6:0], 1'b0};
                            sda_oen_n = sh[6];
                            cnt_n     = cnt - 3'd1;
                        end
                    end
                end
                TX_ACK: begin
                    if (!ph && scl_rise) begin
                        tx_done_n = 1'b1;
                        tx_ack_n  = sda_now;
                        if (sda_now) begin
                            sel_n   = 1'b0;
                            state_n = IGNORE;
                        end else begin
                            ph_n = 1'b1;
                        end
                    end else if (ph && scl_fall) begin
                        state_n = TX_WAIT;
                    end
                end
                IDLE, IGNORE: begin
                end
                default: state_n = IDLE;
            endcase
        end

        // hold SCL from one cycle after entering TX_WAIT until one cycle
        // after the byte is loaded, so SDA settles before SCL is freed
        scl_oen_n = !(bus.ena && !start_c && !stop_c && state == TX_WAIT);
    end

    assign bus.scl_o     = 1'b0;
    assign bus.sda_o     = 1'b0;
    assign bus.scl_oen   = scl_oen_q;
    assign bus.sda_oen   = sda_oen_q;
    assign bus.tx_req    = (state == TX_WAIT);
    assign bus.tx_done   = tx_done_q;
    assign bus.tx_ack    = tx_ack_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.start_det = start_q;
    assign bus.stop_det  = stop_q;
    assign bus.busy      = busy_q;
    assign bus.selected  = sel_q;
    assign bus.rw        = rw_q;

endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
// Directed bench for i2c_slave_byte_ctrl: a bit-banged I2C master on an
// open-drain bus, a host model feeding transmit bytes, and pulse monitors.
module tb_i2c_slave_byte_ctrl;

    localparam int Q = 4;

    logic clk = 1'b0;
    logic nReset = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    always #5 clk = ~clk;

    i2c_slave_byte_ctrl_if bus ();

    i2c_slave_byte_ctrl dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus)
    );

    assign bus.scl_i = scl_m & (bus.scl_oen | bus.scl_o);
    assign bus.sda_i = sda_m & (bus.sda_oen | bus.sda_o);

    int errors = 0;
    int checks = 0;

    int         n_start, n_stop, hold, max_hold, wait_cnt;
    logic [7:0] rx_q[$];
    logic       ack_q[$];
    logic [7:0] host_q[$];

    typedef struct {
        logic [6:0]      sa;
        logic [7:0]      addr;
        logic [1:0][7:0] d;
        int              nb;
        logic            ack_en;
        logic            exp_aack;
        logic            exp_dack;
        int              exp_nrx;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        n_start = 0;
        n_stop = 0;
        max_hold = 0;
        rx_q.delete();
        ack_q.delete();
    endtask

    // pulse monitors, sampled on the falling clock edge
    always @(negedge clk) begin
        if (nReset) begin
            if (bus.rx_valid) rx_q.push_back(bus.rx_data);
            if (bus.tx_done) ack_q.push_back(bus.tx_ack);
            if (bus.start_det) n_start++;
            if (bus.stop_det) n_stop++;
            if (!bus.scl_oen) hold++;
            else hold = 0;
            if (hold > max_hold) max_hold = hold;
        end else begin
            hold = 0;
        end
    end

    // host: answers tx_req 20 clk later with the next queued byte
    always @(negedge clk) begin
        if (!nReset) begin
            bus.tx_valid = 1'b0;
            bus.tx_data = 8'h00;
            wait_cnt = 0;
        end else if (bus.tx_valid) begin
            bus.tx_valid = 1'b0;
        end else if (bus.tx_req && host_q.size() > 0) begin
            wait_cnt++;
            if (wait_cnt == 20) begin
                bus.tx_data = host_q.pop_front();
                bus.tx_valid = 1'b1;
                wait_cnt = 0;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic bitx(input logic b, output logic s);
        int t;
        tick(Q);
        sda_m = b;
        tick(Q);
        scl_m = 1'b1;
        t = 0;
        while (bus.scl_i !== 1'b1 && t < 200) begin
            tick(1);
            t++;
        end
        if (t >= 200) begin
            checks++;
            errors++;
            $display("FAIL scl_release: SCL low for %0d clk, expected release", t);
        end
        tick(Q);
        s = bus.sda_i;
        tick(Q);
        scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        int lat;
        tick(Q);
        sda_m = 1'b1;
        tick(Q);
        scl_m = 1'b1;
        tick(2 * Q);
        sda_m = 1'b0;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            if (bus.start_det && lat == 0) lat = k;
        end
        chk("start_latency", lat, 3);
        tick(2);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        int lat;
        tick(Q);
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b1;
        tick(2 * Q);
        sda_m = 1'b1;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            if (bus.stop_det && lat == 0) lat = k;
        end
        chk("stop_latency", lat, 3);
        tick(2);
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bitx(b[i], s);
        bitx(1'b1, ack);
    endtask

    task automatic rbyte(output logic [7:0] b, input logic nack);
        logic s;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            bitx(1'b1, s);
            b = {b[6:0], s};
        end
        bitx(nack, s);
    endtask

    initial begin
        logic       a, s;
        logic [7:0] b;
        logic [31:0] got;
        vec_t       v;

        tbl[0] = '{7'h50, 8'hA0, {8'hFF, 8'h3C}, 2, 1'b1, 1'b0, 1'b0, 2};
        tbl[1] = '{7'h50, 8'hA2, {8'h00, 8'h55}, 1, 1'b1, 1'b1, 1'b1, 0};
        tbl[2] = '{7'h50, 8'hA0, {8'h00, 8'h22}, 1, 1'b0, 1'b0, 1'b1, 1};
        tbl[3] = '{7'h10, 8'h20, {8'h00, 8'h81}, 1, 1'b1, 1'b0, 1'b0, 1};

        bus.ena = 1'b1;
        bus.slave_addr = 7'h50;
        bus.rx_ack_en = 1'b1;
        clr();
        hold = 0;

        tick(3);
        chk("reset_flags", {bus.scl_oen, bus.sda_oen, bus.scl_o, bus.sda_o,
            bus.rx_valid, bus.tx_req, bus.tx_done, bus.tx_ack,
            bus.start_det, bus.stop_det, bus.busy, bus.selected, bus.rw},
            32'h1800);
        chk("reset_rx_data", bus.rx_data, 8'h00);
        nReset = 1'b1;
        tick(4);

        for (int i = 0; i < 4; i++) begin
            v = tbl[i];
            bus.slave_addr = v.sa;
            bus.rx_ack_en = v.ack_en;
            clr();
            i2c_start();
            chk($sformatf("v%0d_busy", i), bus.busy, 1);
            wbyte(v.addr, a);
            chk($sformatf("v%0d_addr_ack", i), a, v.exp_aack);
            chk($sformatf("v%0d_selected", i), bus.selected, !v.exp_aack);
            for (int j = 0; j < v.nb; j++) begin
                wbyte(v.d[j], a);
                chk($sformatf("v%0d_data_ack%0d", i, j), a, v.exp_dack);
            end
            i2c_stop();
            chk($sformatf("v%0d_rx_count", i), rx_q.size(), v.exp_nrx);
            for (int j = 0; j < v.exp_nrx; j++) begin
                got = (j < rx_q.size()) ? {24'd0, rx_q[j]} : 32'hFFFF_FFFF;
                chk($sformatf("v%0d_rx_data%0d", i, j), got, v.d[j]);
            end
            chk($sformatf("v%0d_start_cnt", i), n_start, 1);
            chk($sformatf("v%0d_stop_cnt", i), n_stop, 1);
            chk($sformatf("v%0d_idle_flags", i),
                {bus.selected, bus.busy, bus.scl_oen, bus.sda_oen}, 4'b0011);
        end

        // read: host answers after 20 clk, master ACKs then NACKs
        bus.slave_addr = 7'h50;
        bus.rx_ack_en = 1'b1;
        clr();
        host_q.push_back(8'h5A);
        host_q.push_back(8'h81);
        i2c_start();
        wbyte(8'hA1, a);
        chk("rd_addr_ack", a, 0);
        chk("rd_rw", bus.rw, 1);
        rbyte(b, 1'b0);
        chk("rd_byte0", b, 8'h5A);
        rbyte(b, 1'b1);
        chk("rd_byte1", b, 8'h81);
        tick(4);
        chk("rd_after_nack", {bus.sda_oen, bus.tx_req, bus.selected}, 3'b100);
        i2c_stop();
        chk("rd_tx_done_cnt", ack_q.size(), 2);
        got = (ack_q.size() == 2) ? {30'd0, ack_q[0], ack_q[1]} : 32'hF;
        chk("rd_tx_acks", got, 2'b01);
        chk("rd_stretch", (max_hold >= 18 && max_hold <= 22), 1);

        // write then repeated START into a read
        clr();
        i2c_start();
        wbyte(8'hA0, a);
        chk("rs_addr_ack", a, 0);
        wbyte(8'h11, a);
        chk("rs_data_ack", a, 0);
        i2c_start();
        wbyte(8'hA1, a);
        chk("rs_addr2_ack", a, 0);
        tick(6);
        chk("rs_start_cnt", n_start, 2);
        chk("rs_rx_data", bus.rx_data, 8'h11);
        chk("rs_rw_req_hold", {bus.rw, bus.tx_req, bus.scl_oen}, 3'b110);
        host_q.push_back(8'hC3);
        rbyte(b, 1'b1);
        chk("rs_tx_byte", b, 8'hC3);
        i2c_stop();

        // STOP after four bits of a data byte
        clr();
        i2c_start();
        wbyte(8'hA0, a);
        bitx(1'b0, s);
        bitx(1'b0, s);
        bitx(1'b1, s);
        bitx(1'b1, s);
        i2c_stop();
        chk("ab_rx_count", rx_q.size(), 0);
        chk("ab_stop_cnt", n_stop, 1);
        chk("ab_flags", {bus.selected, bus.busy, bus.scl_oen, bus.sda_oen},
            4'b0011);

        // reset pulsed while transmitting
        clr();
        host_q.push_back(8'h5A);
        i2c_start();
        wbyte(8'hA1, a);
        bitx(1'b1, s);
        chk("rst_bit7", s, 0);
        bitx(1'b1, s);
        chk("rst_bit6", s, 1);
        tick(4);
        chk("rst_sda_driven", bus.sda_oen, 0);
        nReset = 1'b0;
        #1;
        chk("rst_released", {bus.scl_oen, bus.sda_oen, bus.busy, bus.selected},
            4'b1100);
        tick(3);
        nReset = 1'b1;
        host_q.delete();
        tick(4);
        i2c_stop();
        chk("rst_no_tx_done", ack_q.size(), 0);
        chk("rst_idle", {bus.tx_req, bus.scl_oen, bus.sda_oen}, 3'b011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
